dmg_timer_ctrl: RTL

Programmable timer controller for the CPU-visible TIMA/TMA/TAC registers at FF05–FF07. It sits beside the free-running system divider and selects one divider tap according to TAC. Each falling edge of the gated tap increments TIMA. On TIMA overflow it sequences the delayed TMA reload and the timer interrupt request. It is clocked once per machine cycle and shares the CPU data bus through a tri-state-style output enable.

---
 rtl/dmg_timer_pkg.sv | 30 +++
 rtl/dmg_timer_tick.sv | 32 +++
 rtl/dmg_timer_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the TIMA/TMA/TAC timer block: FSM states,
// register offsets within FF04-FF07 and the TAC divider-tap table.
package dmg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } timer_state_e;

  localparam logic [1:0] TIMA_ADDR = 2'd1;
  localparam logic [1:0] TMA_ADDR  = 2'd2;
  localparam logic [1:0] TAC_ADDR  = 2'd3;

  // Divider bit per tac[1:0], entry 0 in the low three bits: {5, 3, 1, 7}.
  localparam logic [11:0] TAP_TABLE = {3'd5, 3'd3, 3'd1, 3'd7};

  function automatic logic [2:0] tap_index(input logic [1:0] tac_sel);
    logic [2:0] idx;
    case (tac_sel)
      2'b00:   idx = TAP_TABLE[2:0];
      2'b01:   idx = TAP_TABLE[5:3];
      2'b10:   idx = TAP_TABLE[8:6];
      2'b11:   idx = TAP_TABLE[11:9];
      default: idx = TAP_TABLE[2:0];
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/dmg_timer_tick.sv
// Divider tap select and falling-edge detector; tick is high in the cycle
// after the gated tap was high and is now low (TAC writes and divider clears included).
module dmg_timer_tick
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] div_m,
  input  logic [2:0] tac,
  output logic       tick
);

  logic gate_d;
  logic gate_q;

  // Gated tap: enable bit AND the divider bit chosen by the rate field
  always_comb begin
    gate_d = tac[2] & div_m[tap_index(tac[1:0])];
  end

  // Previous gate value for edge detection
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate_d;
    end
  end

  assign tick = gate_q & ~gate_d;

endmodule

// File: rtl/dmg_timer_ctrl.sv
// TIMA/TMA/TAC register file with the overflow -> delayed reload -> IRQ
// sequencer and the CPU read mux for FF05-FF07.
module dmg_timer_ctrl
  import dmg_timer_pkg::*;
#(
  parameter logic [7:0] TMA_RESET  = 8'h00,
  parameter logic [7:0] TIMA_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] div_m,
  input  logic       sel,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       oe,
  output logic       irq_tima
);

  logic [7:0]   tima_d, tima_q;
  logic [7:0]   tma_d, tma_q;
  logic [2:0]   tac_d, tac_q;
  timer_state_e state_d, state_q;
  logic         irq_d, irq_q;
  logic         tick_s;
  logic         wr_tima_s, wr_tma_s, wr_tac_s;
  logic [7:0]   rdata_s;

  dmg_timer_tick u_tick (
    .clk    (clk),
    .nreset (nreset),
    .div_m  (div_m),
    .tac    (tac_q),
    .tick   (tick_s)
  );

  assign wr_tima_s = sel & wr & (addr == TIMA_ADDR);
  assign wr_tma_s  = sel & wr & (addr == TMA_ADDR);
  assign wr_tac_s  = sel & wr & (addr == TAC_ADDR);

  // Register updates and overflow sequencing
  always_comb begin
    tima_d  = tima_q;
    state_d = state_q;
    irq_d   = 1'b0;
    if (wr_tma_s) tma_d = wdata;
    else          tma_d = tma_q;
    if (wr_tac_s) tac_d = wdata[2:0];
    else          tac_d = tac_q;
    case (state_q)
      IDLE: begin
        if (wr_tima_s) begin
          tima_d = wdata;
        end else if (tick_s) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
          end else begin
            tima_d  = tima_q + 8'd1;
          end
        end else begin
          tima_d = tima_q;
        end
      end
      OVF: begin
        // A CPU write during the zero cycle cancels the reload and the IRQ;
        // otherwise the reload (with any TMA written this cycle) wins over a tick.
        if (wr_tima_s) begin
          tima_d  = wdata;
          state_d = IDLE;
        end else begin
          tima_d  = tma_d;
          state_d = RELOAD;
          irq_d   = 1'b1;
        end
      end
      RELOAD: begin
        // TIMA tracks TMA here: TIMA writes and ticks are dropped.
        if (wr_tma_s) tima_d = wdata;
        else          tima_d = tima_q;
        state_d = IDLE;
      end
      default: begin
        tima_d  = tima_q;
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima_q  <= TIMA_RESET;
      tma_q   <= TMA_RESET;
      tac_q   <= 3'b000;
      state_q <= IDLE;
      irq_q   <= 1'b0;
    end else begin
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  assign oe = sel & rd & (addr != 2'd0);

  // CPU read mux; the bus idles high
  always_comb begin
    rdata_s = 8'hFF;
    if (oe) begin
      case (addr)
        TIMA_ADDR: rdata_s = tima_q;
        TMA_ADDR:  rdata_s = tma_q;
        TAC_ADDR:  rdata_s = {5'b11111, tac_q};
        default:   rdata_s = 8'hFF;
      endcase
    end else begin
      rdata_s = 8'hFF;
    end
  end

  assign rdata    = rdata_s;
  assign irq_tima = irq_q;

endmodule
